// File: rtl/packed_word_serializer_pkg.sv
// rtl/packed_word_serializer_pkg.sv - shared constants and state encoding for the word serializer
package packed_word_serializer_pkg;

    localparam int DATAPATH_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/packed_word_serializer_shift_reg.sv
// rtl/packed_word_serializer_shift_reg.sv - parallel-load register that shifts right one word per step
module word_shift_register #(
    parameter int WORD_LENGTH = 8,
    parameter int NUM_WORDS   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_i,
    input  logic                             shift_i,
    input  logic [NUM_WORDS*WORD_LENGTH-1:0] data_i,
    output logic [WORD_LENGTH-1:0]           word_o
);

    logic [NUM_WORDS*WORD_LENGTH-1:0] sr_q;
    logic [NUM_WORDS*WORD_LENGTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            // zero fill so the register reads 0 once every word has left
            sr_d = sr_q >> WORD_LENGTH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign word_o = sr_q[WORD_LENGTH-1:0];

endmodule

// File: rtl/packed_word_serializer.sv
// rtl/packed_word_serializer.sv - drains a packed bank of words one per valid/ready handshake
module packed_word_serializer
    import packed_word_serializer_pkg::*;
#(
    parameter int WORD_LENGTH = DATAPATH_WIDTH,
    parameter int NUM_WORDS   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld,
    input  logic [NUM_WORDS*WORD_LENGTH-1:0] in,
    output logic                             busy,
    output logic [WORD_LENGTH-1:0]           out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             done
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             done_q;
    logic             done_d;
    logic             load;
    logic             shift;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // ld is deliberately not looked at here, even on the final handshake
                if (out_ready) begin
                    shift = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    word_shift_register #(
        .WORD_LENGTH (WORD_LENGTH),
        .NUM_WORDS   (NUM_WORDS)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (in),
        .word_o  (out_data)
    );

    assign busy      = (state_q == ST_SEND);
    assign out_valid = (state_q == ST_SEND);
    assign out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    assign done      = done_q;

endmodule
